// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS adaptive FIR: FSM states,
// parameter-derived widths and a width-generic saturating clamp.
package lms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ERR,
    ST_UPD
  } lms_state_t;

  // Working width of the saturate helper; every intermediate value fits.
  localparam int SAT_W = 128;

  // Right shift that turns an e*x product into a Q2 coefficient increment.
  function automatic int shift_amt(input int data_w, input int coef_w, input int mu_shift);
    return 2 * (data_w - 1) - (coef_w - 2) + mu_shift;
  endfunction

  // Accumulator width large enough that the TAPS-term sum never wraps.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp v to the signed range of a w-bit number; caller truncates to w bits.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                   input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/adaptive_lms_fir_if.sv
// Sample/result bundle of the LMS filter. master = sample source, slave = filter.
interface adaptive_lms_fir_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] filter_in;
  logic                     filter_en;
  logic signed [DATA_W-1:0] desired_in;
  logic                     desired_en;
  logic                     adapt_en;
  logic                     coef_clr;
  logic signed [DATA_W-1:0] filter_out;
  logic                     filter_out_en;
  logic signed [DATA_W-1:0] err_out;
  logic                     busy;
  logic                     overrun;

  modport master (
    output filter_in, filter_en, desired_in, desired_en, adapt_en, coef_clr,
    input  filter_out, filter_out_en, err_out, busy, overrun
  );

  modport slave (
    input  filter_in, filter_en, desired_in, desired_en, adapt_en, coef_clr,
    output filter_out, filter_out_en, err_out, busy, overrun
  );
endinterface

// File: rtl/lms_mac.sv
// Time-shared signed multiplier with registered accumulator.
// prod is combinational so the coefficient update can use it in the same
// cycle; acc either accumulates (acc_sel=1) or loads the product (bypass).
module lms_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 24,
  parameter int ACC_W = 45
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     acc_sel,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  output logic signed [A_W+B_W-1:0] prod,
  output logic signed [ACC_W-1:0] acc
);
  localparam int PROD_W = A_W + B_W;

  logic signed [ACC_W-1:0] acc_reg;

  assign prod = PROD_W'(a) * PROD_W'(b);
  assign acc  = acc_reg;

  // accumulator: clear wins over accumulate/bypass load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_sel ? acc_reg + ACC_W'(prod) : ACC_W'(prod);
    end
  end
endmodule

// File: rtl/adaptive_lms_fir.sv
// Sample-serial LMS adaptive FIR: one multiplier shared between the
// filter MAC pass and the coefficient update pass.
module adaptive_lms_fir
  import lms_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int TAPS     = 32,
  parameter int COEF_W   = 24,
  parameter int MU_SHIFT = 12
) (
  input  logic clk,
  input  logic rst,
  adaptive_lms_fir_if.slave bus
);
  localparam int SH     = shift_amt(DATA_W, COEF_W, MU_SHIFT);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int KW     = $clog2(TAPS);

  if (SH < 0) begin : g_bad_shift
    $error("adaptive_lms_fir: 2*(DATA_W-1)-(COEF_W-2)+MU_SHIFT must be >= 0");
  end
  if (TAPS < 2) begin : g_bad_taps
    $error("adaptive_lms_fir: TAPS must be at least 2");
  end

  lms_state_t state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;

  logic signed [DATA_W-1:0] x_reg [TAPS];
  logic signed [DATA_W-1:0] x_next [TAPS];
  logic signed [COEF_W-1:0] w_reg [TAPS];
  logic signed [COEF_W-1:0] w_next [TAPS];
  logic signed [DATA_W-1:0] d_reg;

  logic signed [DATA_W-1:0] filter_out_reg, err_out_reg;
  logic                     filter_out_en_reg, overrun_reg;

  logic mac_clr, mac_en, mac_acc_sel;
  logic signed [COEF_W-1:0] mac_b;
  logic signed [PROD_W-1:0] mac_prod;
  logic signed [ACC_W-1:0]  mac_acc;

  logic busy, accept, k_last;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [DATA_W-1:0] y_val, e_val;
  logic signed [DATA_W:0]   e_diff;
  logic signed [PROD_W-1:0] upd_sh;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [COEF_W-1:0] w_new;

  assign busy   = (state_reg != ST_IDLE);
  assign accept = (state_reg == ST_IDLE) && bus.filter_en && !bus.coef_clr;
  assign k_last = (k_reg == KW'(TAPS - 1));

  // UPD multiplies e by x[k]; MAC multiplies x[k] by w[k]
  assign mac_b = (state_reg == ST_UPD) ? COEF_W'(err_out_reg) : w_reg[k_reg];

  lms_mac #(
    .A_W  (DATA_W),
    .B_W  (COEF_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .acc_sel(mac_acc_sel),
    .a      (x_reg[k_reg]),
    .b      (mac_b),
    .prod   (mac_prod),
    .acc    (mac_acc)
  );

  // output and error, valid while in ERR
  assign acc_sh = mac_acc >>> (COEF_W - 2);
  assign y_val  = DATA_W'(sat(SAT_W'(acc_sh), DATA_W));
  assign e_diff = {d_reg[DATA_W-1], d_reg} - {y_val[DATA_W-1], y_val};
  assign e_val  = DATA_W'(sat(SAT_W'(e_diff), DATA_W));

  // coefficient update for the current tap, valid while in UPD
  assign upd_sh = mac_prod >>> SH;
  assign w_sum  = SUM_W'(w_reg[k_reg]) + SUM_W'(upd_sh);
  assign w_new  = COEF_W'(sat(SAT_W'(w_sum), COEF_W));

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      assign x_next[gi] = accept ? bus.filter_in : x_reg[gi];
    end else begin : g_body
      assign x_next[gi] = accept ? x_reg[gi-1] : x_reg[gi];
    end
    assign w_next[gi] = (state_reg == ST_UPD && k_reg == KW'(gi)) ? w_new : w_reg[gi];
  end

  // FSM state and tap index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  // next-state, tap sequencing and multiplier control
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    mac_acc_sel = 1'b1;
    if (bus.coef_clr) begin
      state_next = ST_IDLE;
      k_next     = '0;
      mac_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.filter_en) begin
            state_next = ST_MAC;
            k_next     = '0;
            mac_clr    = 1'b1;
          end
        end
        ST_MAC: begin
          mac_en = 1'b1;
          if (k_last) begin
            state_next = ST_ERR;
            k_next     = '0;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
        ST_ERR: begin
          state_next = bus.adapt_en ? ST_UPD : ST_IDLE;
          k_next     = '0;
        end
        ST_UPD: begin
          mac_en      = 1'b1;
          mac_acc_sel = 1'b0;
          if (k_last) begin
            state_next = ST_IDLE;
            k_next     = '0;
          end else begin
            k_next = k_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // delay line, coefficients and desired-sample latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '{default: '0};
      w_reg <= '{default: '0};
      d_reg <= '0;
    end else if (bus.coef_clr) begin
      x_reg <= '{default: '0};
      w_reg <= '{default: '0};
      d_reg <= '0;
    end else begin
      x_reg <= x_next;
      w_reg <= w_next;
      if (bus.desired_en) d_reg <= bus.desired_in;
    end
  end

  // result registers, valid strobe and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filter_out_reg    <= '0;
      err_out_reg       <= '0;
      filter_out_en_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      filter_out_en_reg <= 1'b0;
      if (!bus.coef_clr) begin
        if (state_reg == ST_ERR) begin
          filter_out_reg    <= y_val;
          err_out_reg       <= e_val;
          filter_out_en_reg <= 1'b1;
        end
        if (bus.filter_en && busy) overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.filter_out    = filter_out_reg;
  assign bus.err_out       = err_out_reg;
  assign bus.filter_out_en = filter_out_en_reg;
  assign bus.busy          = busy;
  assign bus.overrun       = overrun_reg;
endmodule
